// File: rtl/alu_arb_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification
// for the two-requester arbitrated ALU.
package alu_arb_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_LTU = 4'b1001;
  localparam logic [3:0] OP_EQ  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_arb_alu.sv
// Purely combinational N-bit ALU; divide-by-zero is resolved by the caller.
module alu_arb_alu
  import alu_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic [N-1:0] res
);

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_MUL:  res = a * b;
      OP_DIV:  res = a / b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_LTU:  res = {{(N-1){1'b0}}, (a < b)};
      OP_EQ:   res = {{(N-1){1'b0}}, (a == b)};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// Round-robin arbiter in front of a single shared ALU; one transaction in
// flight, multiply/divide take MULDIV_LAT execute cycles.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int N          = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req0_op,
  input  logic [3:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_res,
  output logic         rsp_dz
);

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_LAT - 1);

  state_t       state, next_state;
  logic [3:0]   cnt;
  logic [N-1:0] a_q, b_q;
  logic [3:0]   op_q;
  logic         id_q;
  logic         last_grant;
  logic         accept;
  logic         grant_id;
  logic [3:0]   op_sel;
  logic [N-1:0] alu_res;
  logic         dz;

  // last_grant == 1 means req0 has priority on the next contention
  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (req0_valid && (!req1_valid || last_grant)) req0_ready = 1'b1;
          else if (req1_valid)                            req1_ready = 1'b1;
          if (req0_ready || req1_ready) next_state = EXEC;
        end
      end
      EXEC:    if (cnt == 4'd0) next_state = DONE;
      DONE:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign accept    = req0_ready | req1_ready;
  assign grant_id  = req1_ready;
  assign op_sel    = grant_id ? req1_op : req0_op;
  assign rsp_valid = (state == DONE);
  assign dz        = (op_q == OP_DIV) && (b_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 4'd0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      rsp_res    <= '0;
      rsp_id     <= 1'b0;
      rsp_dz     <= 1'b0;
    end else if (accept) begin
      a_q        <= grant_id ? req1_a : req0_a;
      b_q        <= grant_id ? req1_b : req0_b;
      op_q       <= op_sel;
      id_q       <= grant_id;
      last_grant <= grant_id;
      cnt        <= is_multicycle(op_sel) ? MD_LOAD : 4'd0;
    end else if (state == EXEC) begin
      if (cnt == 4'd0) begin
        rsp_res <= dz ? '1 : alu_res;
        rsp_id  <= id_q;
        rsp_dz  <= dz;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  alu_arb_alu #(.N(N)) u_alu (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .res (alu_res)
  );

endmodule

// File: tb/tb_alu_arb.sv
// Directed self-checking bench for alu_arb: reset, arbitration, latency,
// arithmetic, divide-by-zero, backpressure and mid-transaction reset.
module tb_alu_arb;
  import alu_arb_pkg::*;

  localparam int N          = 32;
  localparam int MULDIV_LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_dz;
  logic [N-1:0]  rsp_res;

  int tests = 0;
  int fails = 0;

  alu_arb #(.N(N), .MULDIV_LAT(MULDIV_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_res    (rsp_res),
    .rsp_dz     (rsp_dz)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
  endtask

  // Lone request on port k, then scribble the operands and watch for the
  // response at the expected cycle; rsp_ready is high so it drains at once.
  task automatic runOp(input string tag, input logic k, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic exp_dz);
    int lat;
    lat = ((op == OP_MUL) || (op == OP_DIV)) ? 1 + MULDIV_LAT : 2;
    if (k) applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1, op, a, b);
    else   applyStimulus(1'b1, op, a, b, 1'b0, OP_ADD, 32'd0, 32'd0);
    checkOutput({tag, " ready"}, k ? req1_ready : req0_ready, 32'd1);
    checkOutput({tag, " other ready"}, k ? req0_ready : req1_ready, 32'd0);
    tick;
    applyStimulus(1'b0, OP_XOR, 32'hDEADBEEF, 32'h12345678, 1'b0, OP_SUB, 32'hCAFEF00D, 32'h0);
    for (int i = 1; i < lat; i++) begin
      checkOutput({tag, " early valid"}, rsp_valid, 32'd0);
      tick;
    end
    checkOutput({tag, " valid"}, rsp_valid, 32'd1);
    checkOutput({tag, " res"}, rsp_res, exp_res);
    checkOutput({tag, " id"}, rsp_id, k);
    checkOutput({tag, " dz"}, rsp_dz, exp_dz);
    tick;
    checkOutput({tag, " drained"}, rsp_valid, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd2, 1'b1, OP_ADD, 32'd10, 32'd20);
    checkOutput("reset ready0", req0_ready, 32'd0);
    checkOutput("reset ready1", req1_ready, 32'd0);
    tick;
    tick;
    checkOutput("reset valid", rsp_valid, 32'd0);
    checkOutput("reset res", rsp_res, 32'd0);
    checkOutput("reset id", rsp_id, 32'd0);
    checkOutput("reset dz", rsp_dz, 32'd0);
    checkOutput("reset ready0 b", req0_ready, 32'd0);

    // Contention from reset: grants alternate 0,1,0,1
    rst_n = 1'b1;
    #1;
    for (int t = 0; t < 4; t++) begin
      checkOutput("rr ready0", req0_ready, (t % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("rr ready1", req1_ready, (t % 2 == 1) ? 32'd1 : 32'd0);
      tick;
      checkOutput("rr exec readies", {req0_ready, req1_ready}, 32'd0);
      tick;
      checkOutput("rr valid", rsp_valid, 32'd1);
      checkOutput("rr id", rsp_id, (t % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput("rr res", rsp_res, (t % 2 == 1) ? 32'd30 : 32'd3);
      checkOutput("rr done readies", {req0_ready, req1_ready}, 32'd0);
      tick;
    end

    runOp("add", 1'b0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
    runOp("mul", 1'b1, OP_MUL, 32'h10000, 32'h10000, 32'd0, 1'b0);
    runOp("div", 1'b0, OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0);
    runOp("divz", 1'b1, OP_DIV, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b1);
    runOp("sub", 1'b0, OP_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);
    runOp("or", 1'b0, OP_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0);
    runOp("ltu", 1'b0, OP_LTU, 32'd3, 32'd5, 32'd1, 1'b0);
    runOp("eq", 1'b0, OP_EQ, 32'd7, 32'd8, 32'd0, 1'b0);
    runOp("badop", 1'b0, 4'b0100, 32'd7, 32'd7, 32'd0, 1'b0);

    // Backpressure: req0 was granted last, so req1 wins this contention
    rsp_ready = 1'b0;
    applyStimulus(1'b1, OP_AND, 32'hFF00FF00, 32'h0F0F0F0F, 1'b1, OP_XOR, 32'hF0F0, 32'h0FF0);
    checkOutput("bp ready1", req1_ready, 32'd1);
    checkOutput("bp ready0", req0_ready, 32'd0);
    tick;
    tick;
    for (int i = 0; i < 6; i++) begin
      checkOutput("bp valid", rsp_valid, 32'd1);
      checkOutput("bp res", rsp_res, 32'hFF00);
      checkOutput("bp id", rsp_id, 32'd1);
      checkOutput("bp readies", {req0_ready, req1_ready}, 32'd0);
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp handshake readies", {req0_ready, req1_ready}, 32'd0);
    checkOutput("bp handshake valid", rsp_valid, 32'd1);
    tick;
    checkOutput("bp after valid", rsp_valid, 32'd0);
    checkOutput("bp after ready0", req0_ready, 32'd1);
    checkOutput("bp after ready1", req1_ready, 32'd0);

    // Reset in the middle of a divide from req0
    applyStimulus(1'b1, OP_DIV, 32'd50, 32'd5, 1'b0, OP_ADD, 32'd0, 32'd0);
    checkOutput("mid ready0", req0_ready, 32'd1);
    tick;
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_ADD, 32'd0, 32'd0);
    tick;
    rst_n = 1'b0;
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, OP_ADD, 32'd2, 32'd2);
    checkOutput("mid rst readies", {req0_ready, req1_ready}, 32'd0);
    tick;
    checkOutput("mid rst readies b", {req0_ready, req1_ready}, 32'd0);
    checkOutput("mid rst res", rsp_res, 32'd0);
    checkOutput("mid rst id", rsp_id, 32'd0);
    checkOutput("mid rst dz", rsp_dz, 32'd0);
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_ADD, 32'd0, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      checkOutput("mid no rsp", rsp_valid, 32'd0);
      checkOutput("mid res zero", rsp_res, 32'd0);
    end
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, OP_ADD, 32'd2, 32'd2);
    checkOutput("post rst ready0", req0_ready, 32'd1);
    checkOutput("post rst ready1", req1_ready, 32'd0);
    tick;
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_ADD, 32'd0, 32'd0);
    tick;
    checkOutput("post rst res", rsp_res, 32'd2);
    checkOutput("post rst id", rsp_id, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter N, default 32: operand/result width.
REQ-002 SHALL have parameter MULDIV_LAT, default 4: execute cycles for multiply and divide (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester k holds an operation.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  requester k's operation is accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  N  operands.
REQ-008 SHALL have ports req0_op / req1_op  input  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div (unsigned), 0110 and, 0111 or, 1000 xor, 1001 unsigned A<B, 1010 A==B; any other code yields result 0.
REQ-009 SHALL have port rsp_valid  output  1  a result is held.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-011 SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-012 SHALL have port rsp_res  output  N  result; compare ops give zero-extended 0 or 1.
REQ-013 SHALL have port rsp_dz  output  1  divide by zero occurred.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC and DONE, with exactly one transaction in flight.
REQ-015 In IDLE, a request SHALL be accepted when reqk_valid and reqk_ready are both high; ready SHALL be low in EXEC and DONE.
REQ-016 Arbitration SHALL be round-robin: a lone valid requester is granted; when both are valid, the requester not granted most recently wins; at most one ready is high in any cycle.
REQ-017 reqk_ready MAY depend combinationally on req0_valid, req1_valid and the state, but SHALL NOT depend on rsp_ready.
REQ-018 On acceptance, the block SHALL latch a, b, op and the id, then enter EXEC with a down-counter loaded with 0 for single-cycle ops and MULDIV_LAT-1 for mul or div.
REQ-019 In EXEC, the counter SHALL decrement each cycle; at 0 the block SHALL register the result, rsp_id and rsp_dz and enter DONE.
REQ-020 Latency: if a request is accepted in cycle T, rsp_valid SHALL first be high in cycle T+2 for single-cycle ops and T+1+MULDIV_LAT for mul or div.
REQ-021 In DONE, rsp_valid SHALL be 1 and rsp_res, rsp_id and rsp_dz SHALL be held stable until rsp_ready; the handshake cycle returns to IDLE and no request is accepted in that cycle.
REQ-022 Arithmetic SHALL be modulo 2^N; mul SHALL return the low N bits; div SHALL truncate.
REQ-023 div with b==0 SHALL return all-ones with rsp_dz=1; every other case SHALL give rsp_dz=0.
REQ-024 Requesters SHALL hold their inputs stable while valid and not ready; the block only samples in the acceptance cycle.
REQ-025 Operand changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-026 With rst_n low at a rising edge, the block SHALL go to IDLE with counter 0, rsp_valid 0, rsp_res 0, rsp_id 0 and rsp_dz 0, and the round-robin pointer set so that req0 wins the first contention.
REQ-027 A reset during EXEC or DONE SHALL discard the transaction, and no response SHALL ever be emitted for it.
REQ-028 req0_ready and req1_ready SHALL be 0 during any cycle in which rst_n is low.

Structure
REQ-029 Opcode constants and FSM state encodings SHALL live in a shared package or include, shared with the ALU and the decoder.
REQ-030 The block SHALL instantiate exactly one alu sub-module (N-bit), fed from the latched operand registers; divide-by-zero substitution SHALL be done outside it.
REQ-031 The implementation SHALL contain no other sub-modules.

Verification
REQ-032 Single add: req0 a=5, b=7, op=0000 accepted at T, rsp_ready=1 -> rsp_valid at T+2, rsp_res=12, rsp_id=0, rsp_dz=0.
REQ-033 Contention: both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1, each request is accepted exactly once, and the ready signals are never high together.
REQ-034 Multicycle with MULDIV_LAT=4: req1 mul a=0x10000, b=0x10000 (N=32) -> rsp_valid at T+5, rsp_res=0, rsp_id=1; div 100/7 -> rsp_res=14.
REQ-035 Divide by zero: div a=9, b=0 -> rsp_res=0xFFFFFFFF, rsp_dz=1; the next sub 3-5 -> rsp_res=0xFFFFFFFE, rsp_dz=0.
REQ-036 Backpressure: rsp_ready low for 6 cycles in DONE with both requesters valid -> outputs stable, both ready signals low, and a new accept only in the cycle after the handshake.
REQ-037 Reset mid-EXEC of a div -> no rsp_valid afterwards, all outputs are 0, and the next contention is granted to req0.
